la_wb_master: RTL and testbench
===============================

# la_wb_master

Wishbone classic initiator that turns firmware-driven logic-analyzer commands into single Wishbone read/write cycles toward the wrapped design's slave port (`wbs_*`).

- It lets firmware exercise the wrapped project's register space through the LA lines, independent of the management SoC bus.
- It uses a four-phase command/response handshake suited to slow firmware polling.
- It applies a bounded wait with timeout so a non-responding slave cannot hang the bridge.

## Interface

Parameters
- `TIMEOUT`, default 255: cycles `stb` may stay asserted without `ack` before abort. Legal range is 1..65535.
- `LAT_W`, default 16: width of the latency counter and `rsp_lat_o`. Must satisfy 2^LAT_W > `TIMEOUT`.

Ports
- `wb_clk_i`  in  1  — single clock.
- `wb_rst_i`  in  1  — reset, synchronous, active-high.
- `cmd_valid_i`  in  1  — command request (level, four-phase).
- `cmd_ready_o`  out  1  — bridge idle and able to accept a command.
- `cmd_we_i`  in  1  — 1 = write, 0 = read.
- `cmd_sel_i`  in  4  — byte selects.
- `cmd_adr_i`  in  32  — address.
- `cmd_dat_i`  in  32  — write data.
- `rsp_valid_o`  out  1  — response available.
- `rsp_err_o`  out  1  — transfer timed out.
- `rsp_dat_o`  out  32  — read data.
- `rsp_lat_o`  out  LAT_W  — cycles from `stb` assertion to `ack` or timeout.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each — Wishbone control.
- `wbm_sel_o`  out  4  — byte selects.
- `wbm_adr_o`  out  32  — address.
- `wbm_dat_o`  out  32  — write data.
- `wbm_ack_i`  in  1  — slave acknowledge.
- `wbm_dat_i`  in  32  — slave read data.

## Operation

States and transitions
- IDLE → BUS when `cmd_valid_i`=1. On the same edge, latch we/sel/adr/dat into the `wbm_*` registers and clear the latency counter.
- BUS → DONE on `wbm_ack_i`=1.
  - Read: capture `wbm_dat_i` into `rsp_dat_o`.
  - Write: `rsp_dat_o` is 0.
  - `rsp_err_o`=0.
- BUS → DONE when the latency counter reaches `TIMEOUT` with no ack. Set `rsp_err_o`=1 and `rsp_dat_o`=0.
- DONE → IDLE when `cmd_valid_i`=0.

Outputs by state
- `cmd_ready_o` = (state==IDLE) && !`wb_rst_i`. It is combinational from the state register.
- `wbm_cyc_o` = `wbm_stb_o` = 1 only in BUS. These are registered, with no glitches.
- `wbm_we_o`, `wbm_sel_o`, `wbm_adr_o`, `wbm_dat_o` are stable for the whole of BUS and hold their last values in IDLE/DONE.
- `rsp_valid_o` = 1 only in DONE.
- `rsp_dat_o`, `rsp_err_o`, `rsp_lat_o` are stable throughout DONE and hold until the next transfer's completion.

Latency counter
- Increments every BUS cycle without ack. It saturates and never wraps.
- `rsp_lat_o` takes the counter value at completion.
- Ack on the first stb cycle gives `rsp_lat_o`=0.

Boundary cases
- `wbm_ack_i` outside BUS is ignored.
- Ack on the cycle the counter reaches `TIMEOUT`: ack wins (success, err=0).
- `cmd_valid_i` held high after completion: stays in DONE. There is no re-issue until valid drops.
- `cmd_*` changes during BUS/DONE are ignored.
- Reset mid-BUS:
  - `cyc`/`stb` drop at the reset edge and no response is produced.
  - If `cmd_valid_i` is still high after reset, a new transfer starts from IDLE.
- Reset values of every output:
  - `wbm_*` outputs all 0.
  - `rsp_*` outputs all 0.
  - `cmd_ready_o`=0 while reset is asserted, and 1 on the first cycle after.

## Timing

- Command sampled at edge N: `cyc`/`stb`/`adr` are valid from cycle N+1.
- Ack sampled at edge M: `cyc`/`stb` are low and `rsp_valid_o`=1 from cycle M+1, with `rsp_dat_o` valid the same cycle.
- Zero-wait slave: `stb` is high for exactly 1 cycle, and the command is answered 2 cycles after acceptance.
- Timeout: `stb` is high for exactly `TIMEOUT`+1 cycles, then `rsp_err_o`=1.
- `cmd_valid_i` seen low at edge K in DONE: `cmd_ready_o`=1 from cycle K+1.
- The earliest next command is accepted at edge K+1.
- No combinational path from `wbm_ack_i` to any output.

## Test plan

- Zero-wait read:
  - Stimulus: adr=0x30000004, slave acks on the first stb cycle with data 0xA5A5_1234.
  - Required: `stb` high for 1 cycle, `rsp_dat_o`=0xA5A51234, err=0, lat=0.
- Wait-state write:
  - Stimulus: we=1, sel=0xF, dat=0xDEADBEEF, slave acks after 3 wait cycles.
  - Required: `wbm_dat_o`/`adr` stable for all 4 stb cycles, `rsp_dat_o`=0, lat=3.
- Timeout:
  - Stimulus: TIMEOUT=8, slave never acks.
  - Required: `stb` high 9 cycles, then `rsp_valid_o`=1, err=1, dat=0, lat=8.
- Ack coincident with timeout:
  - Stimulus: TIMEOUT=8, ack on the 9th stb cycle.
  - Required: err=0, read data captured, lat=8.
- Four-phase discipline:
  - Stimulus: hold `cmd_valid_i` high 20 cycles after a response; also toggle `wbm_ack_i` while in IDLE.
  - Required: exactly one bus cycle, response held, `ready` returns 1 cycle after valid drops; stray ack has no effect.
- Reset mid-BUS:
  - Stimulus: assert `wb_rst_i` 1 cycle while `stb` is high, keep `cmd_valid_i` high.
  - Required: `cyc`/`stb` 0 after the reset edge, `rsp_valid_o` never pulses for the aborted transfer, a fresh transfer starts 1 cycle after reset releases.

Source files
------------

// File: rtl/la_wb_master.sv
// Wishbone classic initiator driven by a four-phase logic-analyzer command handshake.
// Issues one single read/write cycle per command and aborts after a bounded wait.
module la_wb_master #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned LAT_W   = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [3:0]       cmd_sel_i,
    input  logic [31:0]      cmd_adr_i,
    input  logic [31:0]      cmd_dat_i,
    output logic             rsp_valid_o,
    output logic             rsp_err_o,
    output logic [31:0]      rsp_dat_o,
    output logic [LAT_W-1:0] rsp_lat_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [LAT_W-1:0] TIMEOUT_C = LAT_W'(TIMEOUT);
    localparam logic [LAT_W-1:0] LAT_MAX_C = {LAT_W{1'b1}};
    localparam logic [LAT_W-1:0] LAT_ONE_C = {{(LAT_W-1){1'b0}}, 1'b1};

    state_e           state_r;
    state_e           state_nxt_s;
    logic [LAT_W-1:0] lat_cnt_r;
    logic             accept_s;
    logic             timeout_s;

    assign cmd_ready_o = (state_r == ST_IDLE) && !wb_rst_i;

    // Next-state decode; ack is checked before timeout so a coincident ack succeeds.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        timeout_s   = (lat_cnt_r == TIMEOUT_C);
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    state_nxt_s = ST_BUS;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (wbm_ack_i || timeout_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUS;
                end
            end
            ST_DONE: begin
                if (!cmd_valid_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Bus outputs, latency counter and response capture, all registered from the next state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= 4'h0;
            wbm_adr_o   <= 32'h0000_0000;
            wbm_dat_o   <= 32'h0000_0000;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_dat_o   <= 32'h0000_0000;
            rsp_lat_o   <= {LAT_W{1'b0}};
            lat_cnt_r   <= {LAT_W{1'b0}};
        end else begin
            wbm_cyc_o   <= (state_nxt_s == ST_BUS);
            wbm_stb_o   <= (state_nxt_s == ST_BUS);
            rsp_valid_o <= (state_nxt_s == ST_DONE);
            if (accept_s) begin
                wbm_we_o  <= cmd_we_i;
                wbm_sel_o <= cmd_sel_i;
                wbm_adr_o <= cmd_adr_i;
                wbm_dat_o <= cmd_dat_i;
                lat_cnt_r <= {LAT_W{1'b0}};
            end
            if (state_r == ST_BUS) begin
                if (wbm_ack_i) begin
                    rsp_err_o <= 1'b0;
                    rsp_dat_o <= wbm_we_o ? 32'h0000_0000 : wbm_dat_i;
                    rsp_lat_o <= lat_cnt_r;
                end else if (timeout_s) begin
                    rsp_err_o <= 1'b1;
                    rsp_dat_o <= 32'h0000_0000;
                    rsp_lat_o <= lat_cnt_r;
                end else if (lat_cnt_r != LAT_MAX_C) begin
                    lat_cnt_r <= lat_cnt_r + LAT_ONE_C;
                end
            end
        end
    end

endmodule

// File: tb/tb_la_wb_master.sv
// Randomized self-checking bench for la_wb_master with a transaction-level reference model.
// Expected stb length, error flag, data and latency are derived from the ack delay chosen per transfer.
module tb_la_wb_master;

    localparam int unsigned TO = 8;
    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [3:0]    cmd_sel;
    logic [31:0]   cmd_adr;
    logic [31:0]   cmd_dat;
    logic          rsp_valid;
    logic          rsp_err;
    logic [31:0]   rsp_dat;
    logic [LW-1:0] rsp_lat;
    logic          wbm_cyc;
    logic          wbm_stb;
    logic          wbm_we;
    logic [3:0]    wbm_sel;
    logic [31:0]   wbm_adr;
    logic [31:0]   wbm_dat;
    logic          wbm_ack;
    logic [31:0]   wbm_dat_in;

    int n_tests = 0;
    int n_fail  = 0;

    la_wb_master #(.TIMEOUT(TO), .LAT_W(LW)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_sel_i   (cmd_sel),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .rsp_valid_o (rsp_valid),
        .rsp_err_o   (rsp_err),
        .rsp_dat_o   (rsp_dat),
        .rsp_lat_o   (rsp_lat),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_sel_o   (wbm_sel),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat),
        .wbm_ack_i   (wbm_ack),
        .wbm_dat_i   (wbm_dat_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command and move past the acceptance edge.
    task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        chk("ready_before_cmd", {63'd0, cmd_ready}, 64'd1);
        cmd_we    = we;
        cmd_sel   = sel;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_valid = 1'b1;
        wbm_ack   = 1'b0;
        step();
    endtask

    // Drive the slave with an ack after 'delay' wait cycles, then check response, hold and release.
    task automatic finish_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                              input logic [31:0] dat, input int delay, input logic [31:0] rdata,
                              input int hold);
        int          stb_cnt = 0;
        bit          done    = 1'b0;
        int          exp_cnt;
        logic        exp_err;
        logic [31:0] exp_dat;
        logic [LW-1:0] exp_lat;
        if (delay <= int'(TO)) begin
            exp_cnt = delay + 1;
            exp_err = 1'b0;
            exp_lat = LW'(delay);
            exp_dat = we ? 32'd0 : rdata;
        end else begin
            exp_cnt = int'(TO) + 1;
            exp_err = 1'b1;
            exp_lat = LW'(TO);
            exp_dat = 32'd0;
        end
        for (int k = 0; k < 40 && !done; k++) begin
            if (wbm_stb) begin
                stb_cnt++;
                chk("bus_adr", {32'd0, wbm_adr}, {32'd0, adr});
                chk("bus_ctl", {27'd0, wbm_cyc, wbm_we, wbm_sel, wbm_dat}, {27'd0, 1'b1, we, sel, dat});
                chk("rsp_valid_in_bus", {63'd0, rsp_valid}, 64'd0);
                wbm_ack    = (k == delay);
                wbm_dat_in = (k == delay) ? rdata : $urandom;
                cmd_adr    = $urandom;
                cmd_dat    = $urandom;
                cmd_we     = ~we;
                step();
            end else begin
                done = 1'b1;
            end
        end
        wbm_ack = 1'b0;
        chk("txn_done", {63'd0, done}, 64'd1);
        chk("stb_cycles", 64'(stb_cnt), 64'(exp_cnt));
        chk("cyc_after", {62'd0, wbm_cyc, wbm_stb}, 64'd0);
        chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, exp_err});
        chk("rsp_dat", {32'd0, rsp_dat}, {32'd0, exp_dat});
        chk("rsp_lat", {48'd0, rsp_lat}, {48'd0, exp_lat});
        for (int h = 0; h < hold; h++) begin
            wbm_ack = 1'($urandom);
            step();
            chk("hold_state", {60'd0, rsp_valid, cmd_ready, wbm_cyc, wbm_stb}, 64'h8);
            chk("hold_rsp", {31'd0, rsp_err, rsp_dat}, {31'd0, exp_err, exp_dat});
        end
        wbm_ack   = 1'b0;
        cmd_valid = 1'b0;
        step();
        chk("release", {61'd0, cmd_ready, rsp_valid, wbm_cyc}, 64'h4);
        chk("rsp_held", {15'd0, rsp_err, rsp_lat, rsp_dat}, {15'd0, exp_err, exp_lat, exp_dat});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rd;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        cmd_sel    = 4'h0;
        cmd_adr    = 32'd0;
        cmd_dat    = 32'd0;
        wbm_ack    = 1'b0;
        wbm_dat_in = 32'd0;
        repeat (3) step();
        chk("reset_wbm", {wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_adr[24:0], wbm_dat}, 64'd0);
        chk("reset_wbm_adr", {32'd0, wbm_adr}, 64'd0);
        chk("reset_rsp", {15'd0, rsp_valid, rsp_err, rsp_lat, rsp_dat[30:0]}, 64'd0);
        chk("reset_rsp_dat", {32'd0, rsp_dat}, 64'd0);
        chk("reset_ready", {63'd0, cmd_ready}, 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

        // Zero-wait read.
        issue(1'b0, 4'hF, 32'h3000_0004, 32'h0);
        finish_txn(1'b0, 4'hF, 32'h3000_0004, 32'h0, 0, 32'hA5A5_1234, 1);
        // Wait-state write.
        issue(1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF);
        finish_txn(1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, 3, 32'h1111_2222, 2);
        // Timeout with no ack.
        issue(1'b0, 4'h3, 32'h3000_0020, 32'h0);
        finish_txn(1'b0, 4'h3, 32'h3000_0020, 32'h0, 1000, 32'h0, 1);
        // Ack on the cycle the counter reaches the limit.
        issue(1'b0, 4'hC, 32'h3000_0024, 32'h0);
        finish_txn(1'b0, 4'hC, 32'h3000_0024, 32'h0, int'(TO), 32'hCAFE_F00D, 0);

        // Stray acks in IDLE, then a long valid hold.
        for (int i = 0; i < 6; i++) begin
            wbm_ack    = 1'(i & 1);
            wbm_dat_in = $urandom;
            step();
            chk("idle_stray_ack", {61'd0, cmd_ready, wbm_stb, rsp_valid}, 64'h4);
        end
        issue(1'b0, 4'h1, 32'h3000_0030, 32'h0);
        finish_txn(1'b0, 4'h1, 32'h3000_0030, 32'h0, 2, 32'h0BAD_CAFE, 20);

        // Reset during BUS with valid held high.
        issue(1'b1, 4'hF, 32'h3000_0040, 32'h5555_AAAA);
        step();
        chk("pre_reset_stb", {63'd0, wbm_stb}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mid_reset_bus", {60'd0, wbm_cyc, wbm_stb, rsp_valid, cmd_ready}, 64'h1);
        chk("mid_reset_rsp", {15'd0, rsp_err, rsp_lat, rsp_dat}, 64'd0);
        step();
        finish_txn(1'b1, 4'hF, 32'h3000_0040, 32'h5555_AAAA, 1, 32'h0, 1);

        // Randomized transfers against the reference model.
        for (int t = 0; t < 40; t++) begin
            we  = 1'($urandom);
            sel = 4'($urandom);
            adr = $urandom;
            dat = $urandom;
            rd  = $urandom;
            issue(we, sel, adr, dat);
            finish_txn(we, sel, adr, dat, int'($urandom_range(0, 12)), rd, int'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
